dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port `data_mem` block. It shares the data memory between the CPU memory stage (`cpu_*`) and the debug/program-loader port (`dbg_*`). Each access is a request/grant/response transaction; the block drives `mem_read`/`mem_write` one access at a time and captures the one-cycle-late read data. It also rejects misaligned or out-of-range addresses before they reach the memory.

## Interface
- `WORD_W`, 64, data width; equals `` `WORD ``
- `ADDR_W`, 64, byte-address width
- `DEPTH`, 32, data-memory depth in words; legal byte addresses are 0..8*DEPTH-8, 8-aligned
- `im_clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `cpu_req`, `dbg_req`  in  1  request; held with its fields stable until the matching `*_gnt`
- `cpu_we`, `dbg_we`  in  1  1 = write, 0 = read
- `cpu_addr`, `dbg_addr`  in  ADDR_W  byte address
- `cpu_wdata`, `dbg_wdata`  in  WORD_W  write data
- `cpu_gnt`, `dbg_gnt`  out  1  one-cycle pulse: request accepted
- `cpu_rvalid`, `dbg_rvalid`  out  1  one-cycle pulse: response (read data or write ack)
- `cpu_rdata`, `dbg_rdata`  out  WORD_W  read data; valid when `*_rvalid` is high and the access was a read
- `cpu_err`, `dbg_err`  out  1  qualifies `*_rvalid`: access rejected
- `mem_read`, `mem_write`  out  1  strobes to `data_mem`; never both high
- `mem_addr`  out  ADDR_W  byte address to `data_mem` (`alu_result`)
- `mem_wdata`  out  WORD_W  to `data_mem` (`read_data2`)
- `mem_rdata`  in  WORD_W  from `data_mem` (`read_data`); valid the cycle after a `mem_read` strobe
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **Arbitration** happens only in IDLE and RESP. It operates on the `req` values present in that cycle.
  - Only one `req` high: that requester wins.
  - Both high: round-robin; the winner is the requester not granted last.
  - The `last` register resets to dbg, so the CPU wins the first tie.
- **Winner recorded:** the winner's we, addr and wdata are registered, and the FSM moves to ISSUE.
- **ISSUE**
  - `*_gnt` is pulsed to the winner.
  - If the address is legal (addr[2:0]==0 and addr[ADDR_W-1:3] < DEPTH), `mem_read` or `mem_write` is asserted with the registered addr/wdata.
  - If the address is illegal, both strobes stay 0 and an error flag is set.
  - Next state: WAIT for a legal read; RESP for a write or an error.
- **WAIT**
  - No strobes.
  - `mem_rdata` is captured into the winner's rdata register at the end of the cycle.
  - Next state: RESP.
- **RESP**
  - The winner's `rvalid` is pulsed, with `err` equal to the error flag.
  - Writes and errors leave `rdata` unchanged.
  - Arbitration runs in this cycle: go to ISSUE if any `req` is high, else IDLE.
- **Requester rules**
  - After `gnt`, a requester may drop `req` or raise it again for a new access.
  - A `req` still high in the RESP cycle is treated as a new request.
- **Output sources:** all outputs are registered or decoded from registered state only. Nothing is combinational from `*_req`.

## Timing
- **Reset values:** state=IDLE, `last`=dbg, and every output is 0 (gnt, rvalid, err, rdata, mem strobes, mem_addr, mem_wdata, busy).
- **Read:** `req` in cycle N (IDLE) → gnt and `mem_read` in N+1 → capture in N+2 → `rvalid` in N+3.
- **Write:** `req` in N → gnt and `mem_write` in N+1 → `rvalid` (ack) in N+2.
- **Error:** gnt in N+1, `rvalid`+`err` in N+2, no memory strobe.
- **Back-to-back throughput:** one read per 3 cycles, one write per 2 cycles. With both requesters saturating, grants strictly alternate.
- **Reset mid-transaction**
  - A strobe already driven in the cycle in which reset is sampled completes at `data_mem` on that edge.
  - The response is dropped, and the FSM returns to IDLE.
- **Simultaneous new requests in RESP:** handled by round-robin. The requester just served loses a tie.

## Test plan
- Single CPU write, then read: cpu write addr 0x10, data 0xDEAD_BEEF in cycle 1. Required:
  - `mem_write` with mem_addr=0x10 in cycle 2, `cpu_rvalid` in cycle 3.
  - A following read of 0x10 returns `cpu_rdata`=0xDEAD_BEEF with `cpu_rvalid` 3 cycles after its req, `cpu_err`=0.
- Tie after reset: both read in the same cycle.
  - CPU granted first; dbg granted in the CPU's RESP cycle + 1.
  - Each gets its own data; dbg `rvalid` 3 cycles after the CPU's.
- Saturation: both issue writes continuously for 10 grants.
  - Grants alternate cpu, dbg, cpu, …; one `mem_write` every 2 cycles.
  - Never `mem_read` and `mem_write` high together.
- Errors:
  - dbg read addr 0x0C (misaligned) → `dbg_gnt`, then `dbg_rvalid`+`dbg_err` one cycle later, no strobes, `dbg_rdata` unchanged.
  - Same response for addr 0x100 with DEPTH=32.
- Reset in WAIT of a CPU read:
  - Next cycle all outputs 0, `busy`=0, no `cpu_rvalid`.
  - A subsequent tie grants the CPU first.
- Idle stability: no requests for 20 cycles → all strobes, gnt and rvalid remain 0, `busy`=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data_mem between the CPU memory
// stage and the debug/loader port, one request/grant/response at a time.
module dmem_arbiter #(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 32
) (
  input  logic              im_clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [WORD_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [WORD_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [ADDR_W-4:0] LP_DEPTH = (ADDR_W-3)'(DEPTH);

  state_t            r_state;
  logic              r_last_dbg;
  logic              r_win_dbg;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_cpu_rdata;
  logic [WORD_W-1:0] r_dbg_rdata;
  logic              r_cpu_gnt;
  logic              r_dbg_gnt;
  logic              r_cpu_rvalid;
  logic              r_dbg_rvalid;
  logic              r_cpu_err;
  logic              r_dbg_err;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_busy;

  logic              w_any;
  logic              w_pick_dbg;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [WORD_W-1:0] w_wdata;
  logic              w_legal;

  // On a tie the requester not granted last wins.
  assign w_any      = cpu_req | dbg_req;
  assign w_pick_dbg = dbg_req & (~cpu_req | ~r_last_dbg);
  assign w_we       = w_pick_dbg ? dbg_we    : cpu_we;
  assign w_addr     = w_pick_dbg ? dbg_addr  : cpu_addr;
  assign w_wdata    = w_pick_dbg ? dbg_wdata : cpu_wdata;
  assign w_legal    = (w_addr[2:0] == 3'b000) &&
                      (w_addr[ADDR_W-1:3] < LP_DEPTH);

  always_ff @(posedge im_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_dbg   <= 1'b1;
      r_win_dbg    <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      unique case (r_state)
        S_IDLE, S_RESP: begin
          if (w_any) begin
            r_state     <= S_ISSUE;
            r_busy      <= 1'b1;
            r_win_dbg   <= w_pick_dbg;
            r_last_dbg  <= w_pick_dbg;
            r_we        <= w_we;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_err       <= ~w_legal;
            r_cpu_gnt   <= ~w_pick_dbg;
            r_dbg_gnt   <= w_pick_dbg;
            r_mem_read  <= w_legal & ~w_we;
            r_mem_write <= w_legal & w_we;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (r_err | r_we) begin
            r_state      <= S_RESP;
            r_cpu_rvalid <= ~r_win_dbg;
            r_dbg_rvalid <= r_win_dbg;
            r_cpu_err    <= ~r_win_dbg & r_err;
            r_dbg_err    <= r_win_dbg & r_err;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // data_mem returns the word one cycle after the read strobe
          r_state      <= S_RESP;
          r_cpu_rvalid <= ~r_win_dbg;
          r_dbg_rvalid <= r_win_dbg;
          if (r_win_dbg) r_dbg_rdata <= mem_rdata;
          else           r_cpu_rdata <= mem_rdata;
        end
      endcase
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign dbg_gnt    = r_dbg_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dbg_rvalid = r_dbg_rvalid;
  assign cpu_err    = r_cpu_err;
  assign dbg_err    = r_dbg_err;
  assign cpu_rdata  = r_cpu_rdata;
  assign dbg_rdata  = r_dbg_rdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of the arbiter and data memory.
module tb_dmem_arbiter;
  localparam int W = 64;
  localparam int A = 64;
  localparam int D = 32;

  logic         im_clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [A-1:0] cpu_addr = '0;
  logic [W-1:0] cpu_wdata = '0;
  logic         dbg_req = 1'b0, dbg_we = 1'b0;
  logic [A-1:0] dbg_addr = '0;
  logic [W-1:0] dbg_wdata = '0;
  logic         cpu_gnt, cpu_rvalid, cpu_err;
  logic         dbg_gnt, dbg_rvalid, dbg_err;
  logic [W-1:0] cpu_rdata, dbg_rdata;
  logic         mem_read, mem_write, busy;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  always #5 im_clk = ~im_clk;

  dmem_arbiter #(.WORD_W(W), .ADDR_W(A), .DEPTH(D)) dut (
    .im_clk(im_clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // data_mem stand-in: synchronous write, registered read
  logic [W-1:0] dm [D];
  always @(posedge im_clk) begin
    if (mem_write) dm[mem_addr[7:3]] <= mem_wdata;
    if (mem_read)  mem_rdata <= dm[mem_addr[7:3]];
  end

  int n_chk = 0, n_pass = 0, cyc = 0, mode = 0;
  logic d_rst = 1'b1;
  logic d_req [2], d_we [2];
  logic [63:0] d_addr [2], d_wdata [2];
  logic seen_gnt [2];

  int g_cyc [2], v_cyc [2];
  logic [63:0] v_rd [2];
  logic v_err [2];
  int gseq [$];
  int n_strobe, n_both, n_mw, n_busy, mw_last, mw_first, mw_badgap;
  logic [63:0] wa;

  logic m_act, m_who, m_we, m_legal, m_last;
  int m_gnt, m_rv, m_next;
  logic [63:0] m_addr, m_wdata, m_val;
  logic [63:0] m_rd [2];
  logic [63:0] ref_mem [D];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd_addr();
    int k = $urandom_range(0, 9);
    logic [63:0] a = 64'($urandom_range(0, D-1)) << 3;
    if (k == 0) a = a | 64'($urandom_range(1, 7));
    else if (k == 1) a = 64'($urandom_range(D, 4*D)) << 3;
    return a;
  endfunction

  task automatic set_req(int r, logic we, logic [63:0] a, logic [63:0] d);
    d_req[r] = 1'b1; d_we[r] = we; d_addr[r] = a; d_wdata[r] = d;
  endtask

  task automatic clear_obs();
    for (int r = 0; r < 2; r++) begin
      g_cyc[r] = -1; v_cyc[r] = -1; v_rd[r] = '0; v_err[r] = 1'b0;
    end
    gseq.delete();
    n_strobe = 0; n_both = 0; n_mw = 0; n_busy = 0;
    mw_last = -1; mw_first = -1; mw_badgap = 0; wa = '0;
  endtask

  // Transaction-level reference: one access in flight; gnt one cycle
  // after arbitration, response two (write/error) or three (read) after.
  task automatic model_check();
    logic ecg, edg, ecv, edv, ece, ede, emr, emw, eb;
    int idx;
    ecg = m_act && !m_who && cyc == m_gnt;
    edg = m_act && m_who && cyc == m_gnt;
    emr = m_act && cyc == m_gnt && m_legal && !m_we;
    emw = m_act && cyc == m_gnt && m_legal && m_we;
    ecv = m_act && !m_who && cyc == m_rv;
    edv = m_act && m_who && cyc == m_rv;
    ece = ecv && !m_legal;
    ede = edv && !m_legal;
    eb  = m_act && cyc >= m_gnt && cyc <= m_rv;
    if (m_act && cyc == m_rv && m_legal && !m_we) m_rd[m_who] = m_val;
    chk("flags", 64'({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err,
                      dbg_err, mem_read, mem_write, busy}),
        64'({ecg, edg, ecv, edv, ece, ede, emr, emw, eb}));
    chk("cpu_rdata", cpu_rdata, m_rd[0]);
    chk("dbg_rdata", dbg_rdata, m_rd[1]);
    if (emr || emw) chk("mem_addr", mem_addr, m_addr);
    if (emw) chk("mem_wdata", mem_wdata, m_wdata);
    if (reset) begin
      m_act = 1'b0; m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
      m_next = cyc + 1;
    end else if (cyc >= m_next && (cpu_req || dbg_req)) begin
      m_who   = (cpu_req && dbg_req) ? !m_last : dbg_req;
      m_last  = m_who;
      m_we    = m_who ? dbg_we : cpu_we;
      m_addr  = m_who ? dbg_addr : cpu_addr;
      m_wdata = m_who ? dbg_wdata : cpu_wdata;
      m_legal = (m_addr % 8 == 0) && (m_addr / 8 < D);
      m_act   = 1'b1;
      m_gnt   = cyc + 1;
      m_rv    = cyc + ((m_legal && !m_we) ? 3 : 2);
      m_next  = m_rv;
      if (m_legal) begin
        idx = int'(m_addr / 8);
        if (m_we) ref_mem[idx] = m_wdata;
        else m_val = ref_mem[idx];
      end
    end
  endtask

  task automatic observe();
    seen_gnt[0] = cpu_gnt;
    seen_gnt[1] = dbg_gnt;
    if (cpu_gnt) begin gseq.push_back(0); if (g_cyc[0] < 0) g_cyc[0] = cyc; end
    if (dbg_gnt) begin gseq.push_back(1); if (g_cyc[1] < 0) g_cyc[1] = cyc; end
    if (cpu_rvalid && v_cyc[0] < 0) begin
      v_cyc[0] = cyc; v_rd[0] = cpu_rdata; v_err[0] = cpu_err;
    end
    if (dbg_rvalid && v_cyc[1] < 0) begin
      v_cyc[1] = cyc; v_rd[1] = dbg_rdata; v_err[1] = dbg_err;
    end
    if (mem_read || mem_write) n_strobe++;
    if (mem_read && mem_write) n_both++;
    if (busy) n_busy++;
    if (mem_write) begin
      if (mw_last >= 0 && cyc - mw_last != 2) mw_badgap++;
      if (mw_first < 0) begin mw_first = cyc; wa = mem_addr; end
      mw_last = cyc;
      n_mw++;
    end
  endtask

  task automatic cycle();
    @(posedge im_clk);
    #1;
    cyc++;
    for (int r = 0; r < 2; r++) begin
      if (mode == 1 && seen_gnt[r])
        set_req(r, 1'b1, 64'($urandom_range(0, D-1)) << 3, rnd64());
      else if (mode == 2 && (seen_gnt[r] || !d_req[r])) begin
        set_req(r, 1'($urandom_range(0, 1)), rnd_addr(), rnd64());
        d_req[r] = ($urandom_range(0, 2) != 0);
      end else if (seen_gnt[r]) d_req[r] = 1'b0;
    end
    reset = d_rst;
    cpu_req = d_req[0]; cpu_we = d_we[0];
    cpu_addr = d_addr[0]; cpu_wdata = d_wdata[0];
    dbg_req = d_req[1]; dbg_we = d_we[1];
    dbg_addr = d_addr[1]; dbg_wdata = d_wdata[1];
    @(negedge im_clk);
    model_check();
    observe();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  int s, alt_bad;

  initial begin
    for (int i = 0; i < D; i++) begin dm[i] = '0; ref_mem[i] = '0; end
    for (int r = 0; r < 2; r++) begin
      d_req[r] = 1'b0; d_we[r] = 1'b0; d_addr[r] = '0; d_wdata[r] = '0;
      seen_gnt[r] = 1'b0; m_rd[r] = '0;
    end
    m_act = 1'b0; m_last = 1'b1; m_next = 0; m_who = 1'b0; m_we = 1'b0;
    m_legal = 1'b0; m_gnt = 0; m_rv = 0; m_addr = '0; m_wdata = '0; m_val = '0;
    clear_obs();
    repeat (2) @(posedge im_clk);
    #1;
    chk("reset_outputs", 64'(|{cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid,
        cpu_err, dbg_err, cpu_rdata, dbg_rdata, mem_read, mem_write,
        mem_addr, mem_wdata, busy}), 64'd0);
    d_rst = 1'b0;

    // cpu write 0x10, then read it back
    s = cyc + 1; clear_obs();
    set_req(0, 1'b1, 64'h10, 64'hDEAD_BEEF);
    run(6);
    chk("wr_gnt_lat", 64'(g_cyc[0] - s), 64'd1);
    chk("wr_strobe_lat", 64'(mw_first - s), 64'd1);
    chk("wr_strobe_addr", wa, 64'h10);
    chk("wr_ack_lat", 64'(v_cyc[0] - s), 64'd2);
    s = cyc + 1; clear_obs();
    set_req(0, 1'b0, 64'h10, '0);
    run(6);
    chk("rd_lat", 64'(v_cyc[0] - s), 64'd3);
    chk("rd_data", v_rd[0], 64'hDEAD_BEEF);
    chk("rd_err", 64'(v_err[0]), 64'd0);

    // tie after reset: cpu first, dbg one cycle after cpu's RESP
    set_req(1, 1'b1, 64'h18, 64'hC0FFEE);
    run(5);
    s = cyc + 1; clear_obs();
    set_req(0, 1'b0, 64'h10, '0);
    set_req(1, 1'b0, 64'h18, '0);
    run(10);
    chk("tie_cpu_gnt", 64'(g_cyc[0] - s), 64'd1);
    chk("tie_dbg_gnt", 64'(g_cyc[1] - s), 64'd4);
    chk("tie_rv_gap", 64'(v_cyc[1] - v_cyc[0]), 64'd3);
    chk("tie_cpu_data", v_rd[0], 64'hDEAD_BEEF);
    chk("tie_dbg_data", v_rd[1], 64'hC0FFEE);

    // saturation with writes: strict alternation, one write per 2 cycles
    clear_obs();
    set_req(0, 1'b1, 64'h20, rnd64());
    set_req(1, 1'b1, 64'h28, rnd64());
    mode = 1;
    for (int i = 0; i < 40 && gseq.size() < 10; i++) cycle();
    mode = 0;
    alt_bad = 0;
    for (int i = 1; i < gseq.size(); i++)
      if (gseq[i] == gseq[i-1]) alt_bad++;
    chk("sat_grants", 64'(gseq.size()), 64'd10);
    chk("sat_first_cpu", 64'(gseq.size() > 0 ? gseq[0] : -1), 64'd0);
    chk("sat_alternate", 64'(alt_bad), 64'd0);
    chk("sat_writes", 64'(n_mw), 64'd10);
    chk("sat_gap", 64'(mw_badgap), 64'd0);
    chk("sat_no_both", 64'(n_both), 64'd0);
    run(6);

    // rejected addresses: misaligned and out of range
    for (int k = 0; k < 2; k++) begin
      s = cyc + 1; clear_obs();
      set_req(1, 1'b0, (k == 0) ? 64'h0C : 64'h100, '0);
      run(5);
      chk("err_gnt_lat", 64'(g_cyc[1] - s), 64'd1);
      chk("err_rv_lat", 64'(v_cyc[1] - s), 64'd2);
      chk("err_flag", 64'(v_err[1]), 64'd1);
      chk("err_rdata_kept", v_rd[1], 64'hC0FFEE);
      chk("err_no_strobe", 64'(n_strobe), 64'd0);
    end

    // reset during WAIT of a cpu read
    set_req(0, 1'b0, 64'h10, '0);
    cycle();
    cycle();
    d_rst = 1'b1;
    cycle();
    d_rst = 1'b0;
    clear_obs();
    cycle();
    chk("rst_outputs", 64'(|{cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid,
        cpu_err, dbg_err, cpu_rdata, dbg_rdata, mem_read, mem_write,
        mem_addr, mem_wdata}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    run(4);
    chk("rst_no_rvalid", 64'(v_cyc[0]), 64'hFFFF_FFFF_FFFF_FFFF);
    s = cyc + 1; clear_obs();
    set_req(0, 1'b0, 64'h10, '0);
    set_req(1, 1'b0, 64'h18, '0);
    run(10);
    chk("rst_tie_cpu", 64'(g_cyc[0] - s), 64'd1);
    chk("rst_tie_dbg", 64'(g_cyc[1] - s), 64'd4);

    // idle stability
    clear_obs();
    run(20);
    chk("idle_activity", 64'(n_strobe + n_busy + gseq.size()), 64'd0);
    chk("idle_rvalid", 64'(v_cyc[0] + v_cyc[1]), 64'hFFFF_FFFF_FFFF_FFFE);

    // random traffic
    clear_obs();
    mode = 2;
    run(1500);
    mode = 0;
    chk("rand_no_both", 64'(n_both), 64'd0);
    for (int r = 0; r < 2; r++) d_req[r] = 1'b0;
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
